load_store_unit: RTL
====================

# load_store_unit

Sits between the single-cycle RV32I core's memory stage and the 16 KB byte-addressed unified RAM. It converts RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into the RAM's full-word accesses. Loads are sign- or zero-extended. Partial stores use read-modify-write on the word-aligned location. Misaligned, out-of-range and illegal accesses are reported through a request/response handshake.

## Interface
- `MEM_SIZE`, 16384, RAM size in bytes; legal word addresses are 0 .. MEM_SIZE-4.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: core presents a request.
- `req_ready` out 1: unit accepts a request; `req_ready = (state==IDLE)`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I funct3.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data; the low byte or halfword is used for SB/SH.
- `resp_valid` out 1: one-cycle response pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 2: 00 ok, 01 misaligned, 10 access fault, 11 illegal funct3.
- `mem_addr` out 32: to RAM `data_address`; always word-aligned (`addr & ~3`).
- `mem_read` out 1: RAM read strobe.
- `mem_write` out 1: RAM write strobe; the write commits on the next rising edge.
- `mem_wdata` out 32: to RAM `data_in`, little-endian.
- `mem_rdata` in 32: from RAM `data_out`; combinational and valid in any cycle with `mem_read`=1.

## Operation
- States: IDLE, ACCESS, RMW_RD, RMW_WR, RESP.
- On acceptance (`req_valid && req_ready`), the unit registers we, funct3, addr and wdata. It then checks the request in this priority order; the first match wins:
  - Illegal funct3 → err 11. Illegal funct3 is anything outside the load or store set listed above.
  - Misaligned → err 01. LH/LHU/SH misaligned means addr[0]=1. LW/SW misaligned means addr[1:0]≠0.
  - Out of range → err 10. Out of range means `(addr & ~3) > MEM_SIZE-4`; the comparison is unsigned, 32-bit.
  - On any error: next state is RESP and no memory strobe is raised.
- Routing of legal requests:
  - Loads and SW go to ACCESS.
  - SB and SH go to RMW_RD.
- ACCESS:
  - Load: `mem_read`=1 and the unit captures `mem_rdata`.
  - SW: `mem_write`=1 with `mem_wdata`=wdata.
  - Next state: RESP.
- RMW_RD: `mem_read`=1; the unit captures the old word. Next state: RMW_WR.
- RMW_WR: `mem_write`=1.
  - SB replaces byte lane addr[1:0] with wdata[7:0].
  - SH replaces lanes addr[1]*2 .. +1 with wdata[15:0].
  - All other lanes keep the old word. Next state: RESP.
- Load extraction from the captured word:
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- RESP: `resp_valid`=1 with `resp_rdata` and `resp_err`. Next state: IDLE.
- Strobe rules:
  - `mem_read` and `mem_write` are never both 1.
  - Both strobes are 0 outside ACCESS, RMW_RD and RMW_WR.
  - `mem_addr` and `mem_wdata` are 0 whenever no strobe is active.

## Timing
- Reset:
  - State goes to IDLE and all registered request fields clear to 0.
  - `resp_valid`, `resp_rdata`, `resp_err`, `mem_read`, `mem_write`, `mem_addr` and `mem_wdata` are all 0.
  - `req_ready` is 1 in the first cycle after reset is released and 0 while `rst`=1.
- Latency counts from the accepting edge E0 to the cycle in which `resp_valid` is high:
  - Load or SW: ACCESS, then RESP → `resp_valid` in the 2nd cycle after E0.
  - SB/SH: RMW_RD, RMW_WR, RESP → 3rd cycle. The RAM write commits at the edge that ends RMW_WR.
  - Error: RESP in the 1st cycle after E0.
- Throughput: one request in flight. `req_ready`=0 from the cycle after E0 through RESP. A request can be accepted in the cycle after RESP.
- `req_*` inputs are don't-care after acceptance, because all request fields are registered.
- `resp_valid` is a single-cycle pulse; there is no backpressure on the response.
- Reset mid-operation:
  - `rst` high in any state forces IDLE at that edge.
  - A write already committed stays committed.
  - An RMW aborted in RMW_RD writes nothing.
  - No `resp_valid` is produced for the aborted request.
- Address wrap: no arithmetic is done on `addr` beyond masking, so 0xFFFF_FFFC yields an access fault with no strobe.

## Test plan
- Reset for 2 cycles → all outputs 0, then `req_ready`=1. Assert `rst` in the RMW_RD cycle of an SB → no `mem_write` and no `resp_valid`.
- SW addr 0x100 data 0xDEADBEEF, then LW 0x100 → write strobe 1 cycle after accept; LW `resp_rdata`=0xDEADBEEF, `resp_err`=00, `resp_valid` 2 cycles after accept.
- With 0xDEADBEEF at 0x100:
  - LB 0x103 → 0xFFFFFFDE.
  - LBU 0x103 → 0x000000DE.
  - LH 0x102 → 0xFFFFDEAD.
  - LHU 0x100 → 0x0000BEEF.
- With 0xDEADBEEF at 0x100, SB 0x101 data 0x12, then SH 0x102 data 0x5678 → LW 0x100 returns 0x567812EF. Each partial store shows one read cycle followed by one write cycle at `mem_addr`=0x100.
- Error cases, each with `resp_valid` 1 cycle after accept and no strobe:
  - LW 0x102 → err 01.
  - SH 0x101 → err 01.
  - LW 0x4000 → err 10.
  - LW 0x3FFC → ok.
  - Load funct3=011 → err 11.
- Back-to-back: hold `req_valid`=1 with 3 LW requests → `req_ready` is high only in IDLE. Responses arrive in order, with one accept every 3 cycles.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store adapter onto a full-word, byte-addressed RAM.
// Sub-word stores use read-modify-write; bad requests get an error response instead of a RAM access.
module load_store_unit #(
  parameter int unsigned MEM_SIZE = 16384
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic [1:0]  resp_err_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic [2:0]  dbg_state_o
);

  // Handshake: a request is taken at a rising edge where req_valid_i && req_ready_o;
  // the response is a single-cycle resp_valid_o pulse that cannot be stalled.
  typedef enum logic [2:0] {IDLE, ACCESS, RMW_RD, RMW_WR, RESP} state_t;

  localparam logic [31:0] MAX_WORD = 32'(MEM_SIZE - 4);

  state_t      state_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic [1:0]  resp_err_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;

  logic [31:0] word_addr_d;
  logic        illegal_d;
  logic        misaligned_d;
  logic        out_of_range_d;
  logic [1:0]  err_d;

  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] lane,
                                          input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*lane +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b100:  extract = {24'b0, b};
      3'b101:  extract = {16'b0, h};
      default: extract = w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [2:0] f3, input logic [1:0] lane,
                                        input logic [31:0] old, input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    if (f3 == 3'b000) r[8*lane +: 8] = wd[7:0];
    else if (lane[1]) r[31:16] = wd[15:0];
    else              r[15:0]  = wd[15:0];
    merge = r;
  endfunction

  always_comb begin
    word_addr_d    = {req_addr_i[31:2], 2'b00};
    illegal_d      = req_we_i ? (req_funct3_i > 3'b010)
                              : !(req_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misaligned_d   = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                     ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
    out_of_range_d = word_addr_d > MAX_WORD;
    if (illegal_d)           err_d = 2'b11;
    else if (misaligned_d)   err_d = 2'b01;
    else if (out_of_range_d) err_d = 2'b10;
    else                     err_d = 2'b00;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'b0;
      addr_q       <= 32'b0;
      wdata_q      <= 32'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'b0;
      resp_err_q   <= 2'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= 32'b0;
      mem_wdata_q  <= 32'b0;
    end else begin
      // Strobes and response are asserted only for the one state that owns them.
      resp_valid_q <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= 32'b0;
      mem_wdata_q  <= 32'b0;
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            we_q         <= req_we_i;
            funct3_q     <= req_funct3_i;
            addr_q       <= req_addr_i;
            wdata_q      <= req_wdata_i;
            resp_rdata_q <= 32'b0;
            resp_err_q   <= err_d;
            if (err_d != 2'b00) begin
              resp_valid_q <= 1'b1;
              state_q      <= RESP;
            end else if (req_we_i && (req_funct3_i != 3'b010)) begin
              mem_read_q <= 1'b1;
              mem_addr_q <= word_addr_d;
              state_q    <= RMW_RD;
            end else begin
              mem_read_q  <= !req_we_i;
              mem_write_q <= req_we_i;
              mem_addr_q  <= word_addr_d;
              mem_wdata_q <= req_we_i ? req_wdata_i : 32'b0;
              state_q     <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (!we_q) resp_rdata_q <= extract(funct3_q, addr_q[1:0], mem_rdata_i);
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RMW_RD: begin
          mem_write_q <= 1'b1;
          mem_addr_q  <= {addr_q[31:2], 2'b00};
          mem_wdata_q <= merge(funct3_q, addr_q[1:0], mem_rdata_i, wdata_q);
          state_q     <= RMW_WR;
        end
        RMW_WR: begin
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          resp_rdata_q <= 32'b0;
          resp_err_q   <= 2'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o  = (state_q == IDLE) && !rst_i;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_read_o   = mem_read_q;
  assign mem_write_o  = mem_write_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign dbg_state_o  = state_q;

endmodule
